// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin sharing of one external registered multiplier among NREQ requesters.
module mul_rr_sched #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int MUL_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   input  logic [2*W-1:0]      mul_c,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [2*W-1:0]      rsp_data,
   output logic                busy
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW:0]     idx;
   logic            found;
   logic            hs;
   logic [NREQ-1:0] tag [0:MUL_LAT];

   // first valid requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         idx = (idx >= (PW+1)'(NREQ)) ? idx - (PW+1)'(NREQ) : idx;
         if (!found && req_valid[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   assign req_ready = (en && found && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
   assign hs        = |req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         mul_a <= '0;
         mul_b <= '0;
         for (int s = 0; s <= MUL_LAT; s++) tag[s] <= '0;
      end else begin
         tag[0] <= req_ready;
         for (int s = 1; s <= MUL_LAT; s++) tag[s] <= tag[s-1];
         if (hs) begin
            ptr   <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
            mul_a <= req_a[win*W +: W];
            mul_b <= req_b[win*W +: W];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s <= MUL_LAT; s++) busy = busy | (|tag[s]);
   end

   assign rsp_valid = tag[MUL_LAT];
   assign rsp_data  = (|rsp_valid) ? mul_c : '0;
endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched: directed checks of mul_rr_sched with a behavioural one-stage multiplier.
module tb_mul_rr_sched;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic                clk;
   logic                rst;
   logic                en;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;
   logic [NREQ-1:0]     req_ready;
   logic [W-1:0]        mul_a;
   logic [W-1:0]        mul_b;
   logic [2*W-1:0]      mul_c;
   logic [NREQ-1:0]     rsp_valid;
   logic [2*W-1:0]      rsp_data;
   logic                busy;
   int                  checks;
   int                  errors;

   mul_rr_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(1)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external multiplier, latency 1, deliberately not reset so stale products linger
   always_ff @(posedge clk) mul_c <= mul_a * mul_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   int er [0:4] = '{1, 2, 4, 8, 1};
   int ev [0:4] = '{0, 1, 2, 4, 8};
   int ed [0:4] = '{0, 10, 20, 30, 40};

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      #2;
      req_valid = 4'hF; en = 1'b1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      tick();
      tick();
      rst = 1'b0; req_valid = '0;
      #1;
      chk("idle_ready", req_ready, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_data", rsp_data, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mul_a", mul_a, 0);
      chk("idle_mul_b", mul_b, 0);

      // single request from requester 0
      set_op(0, 8'd2, 8'd3);
      req_valid = 4'b0001;
      #1;
      chk("single_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("single_mul_a", mul_a, 2);
      chk("single_mul_b", mul_b, 3);
      chk("single_busy_issue", busy, 1);
      chk("single_no_early_rsp", rsp_valid, 0);
      tick();
      chk("single_rsp_valid", rsp_valid, 4'b0001);
      chk("single_rsp_data", rsp_data, 6);
      chk("single_busy_rsp", busy, 1);
      tick();
      chk("single_rsp_gone", rsp_valid, 0);
      chk("single_data_zero", rsp_data, 0);
      chk("single_busy_done", busy, 0);

      // reset pointer, then full contention
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), 8'd10);
      req_valid = 4'hF;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("rr_ready_%0d", c), req_ready, er[c]);
         tick();
         chk($sformatf("rr_rsp_valid_%0d", c), rsp_valid, ev[c]);
         chk($sformatf("rr_rsp_data_%0d", c), rsp_data, ed[c]);
      end
      req_valid = '0;
      tick();
      chk("rr_tail_valid", rsp_valid, 4'b0001);
      chk("rr_tail_data", rsp_data, 10);
      tick();
      chk("rr_drained", busy, 0);
      chk("rr_idle_data", rsp_data, 0);

      // pointer wrap and skip: ptr is 1 here
      req_valid = 4'b0100;
      #1;
      chk("wrap_ready_req2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0011;
      #1;
      chk("wrap_ready_req0", req_ready, 4'b0001);
      tick();
      chk("wrap_rsp2_valid", rsp_valid, 4'b0100);
      chk("wrap_rsp2_data", rsp_data, 30);
      chk("wrap_ready_req1", req_ready, 4'b0010);
      tick();
      chk("wrap_rsp0_valid", rsp_valid, 4'b0001);
      chk("wrap_rsp0_data", rsp_data, 10);
      req_valid = 4'hF;
      #1;
      chk("wrap_ptr_is_2", req_ready, 4'b0100);
      req_valid = '0;
      tick();
      chk("wrap_rsp1_valid", rsp_valid, 4'b0010);
      chk("wrap_rsp1_data", rsp_data, 20);
      tick();
      chk("wrap_idle", busy, 0);

      // en gating and drain: ptr is 2 here
      req_valid = 4'hF;
      #1;
      chk("en_ready_req2", req_ready, 4'b0100);
      tick();
      chk("en_ready_req3", req_ready, 4'b1000);
      tick();
      chk("en_rsp2_valid", rsp_valid, 4'b0100);
      chk("en_rsp2_data", rsp_data, 30);
      en = 1'b0;
      #1;
      chk("en_low_ready", req_ready, 0);
      tick();
      chk("en_rsp3_valid", rsp_valid, 4'b1000);
      chk("en_rsp3_data", rsp_data, 40);
      chk("en_mul_a_hold", mul_a, 4);
      tick();
      chk("en_drain_valid", rsp_valid, 0);
      chk("en_drain_busy", busy, 0);
      chk("en_drain_mul_a", mul_a, 4);
      en = 1'b1;
      #1;
      chk("en_ptr_frozen", req_ready, 4'b0001);
      req_valid = '0;

      // reset mid-flight, then maximum operands
      set_op(0, 8'hFF, 8'hFF);
      req_valid = 4'b0001;
      #1;
      tick();
      chk("max_mul_a", mul_a, 8'hFF);
      chk("max_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_ready", req_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mul_a", mul_a, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      req_valid = '0;
      tick();
      rst = 1'b0;
      #1;
      chk("postrst_rsp_valid", rsp_valid, 0);
      chk("postrst_rsp_data", rsp_data, 0);
      tick();
      chk("postrst_rsp_valid2", rsp_valid, 0);
      req_valid = 4'b0001;
      #1;
      chk("reissue_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      chk("max_rsp_valid", rsp_valid, 4'b0001);
      chk("max_rsp_data", rsp_data, 16'hFE01);
      tick();
      chk("max_done", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_rr_sched.md
Name: mul_rr_sched

Overview:
- Round-robin scheduler that shares one registered W x W multiplier among NREQ requesters.
- The multiplier is external and has fixed latency MUL_LAT; it samples its operands at posedge clk and presents the product MUL_LAT edges later.
- This block arbitrates requests, registers the operands into the multiplier, tracks which requester owns each in-flight product, and routes results back as one-cycle responses.
- The pipeline is fully pipelined: one issue per cycle, no response backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- MUL_LAT, 1, multiplier latency in clock edges from its operand sample to a valid product (>=1).

Ports:
- clk  input  1  single clock, posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  issue enable; when low, no grants are made and in-flight work still drains.
- req_valid  input  NREQ  per-requester request.
- req_a  input  NREQ*W  operand A; requester i uses bits [i*W +: W].
- req_b  input  NREQ*W  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot-or-zero grant, combinational.
- mul_a  output  W  registered operand A to the multiplier.
- mul_b  output  W  registered operand B to the multiplier.
- mul_c  input  2*W  product from the multiplier.
- rsp_valid  output  NREQ  one-hot-or-zero response strobe, one cycle.
- rsp_data  output  2*W  product for the requester flagged by rsp_valid; 0 when no response.
- busy  output  1  high while any operation is in flight.

Behaviour:

Arbitration
- Priority pointer ptr has range 0..NREQ-1.
- Winner: the first i with req_valid[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
- req_ready[winner]=1 only when en=1. All other req_ready bits are 0.
- Requests are dropped combinationally with no latching; a requester holds req_valid and its operands until req_ready=1.
- Handshake occurs when req_valid[i] & req_ready[i] at a posedge.
- After a handshake by requester i: ptr <= (i+1) mod NREQ.
- With no handshake, ptr holds its value.

Issue stage
- On handshake: mul_a <= req_a[i], mul_b <= req_b[i], and tag stage 0 <= onehot(i).
- With no handshake: mul_a and mul_b hold their values (no toggling), and tag stage 0 <= 0.

Tag pipe
- Stages 0..MUL_LAT, each NREQ bits one-hot-or-zero; it shifts every cycle unconditionally.
- rsp_valid = stage MUL_LAT.
- rsp_data = mul_c when |rsp_valid, else 0.

Latency
- For a handshake at edge k, rsp_valid[i] is high for exactly the one cycle following edge k+MUL_LAT+... counted as: the multiplier samples at edge k+1, and the response is visible after edge k+MUL_LAT.
- Equivalently, with MUL_LAT=1, the response appears in the cycle after the first edge following the handshake edge.
- Back-to-back handshakes give back-to-back responses in issue order.

busy
- busy = OR of all tag stages.

Reset (asynchronous on rst=1)
- ptr=0, mul_a=0, mul_b=0, all tag stages=0.
- Therefore rsp_valid=0, rsp_data=0, busy=0 immediately.
- req_ready=0 while rst=1.
- In-flight products are discarded. A stale mul_c after reset is never reported because the tags are cleared.

Boundary conditions
- Single requester continuously valid: granted every cycle, throughput 1 per cycle.
- All requesters valid: grants cycle strictly i, i+1, ... with no requester waiting more than NREQ-1 grants.
- en deasserted mid-stream: no new grants, ptr frozen, and already-issued operations still complete and respond.
- ptr = NREQ-1 with a grant: ptr wraps to 0.
- Operands at maximum (all ones): rsp_data = (2^W-1)^2 with no truncation; for W=8 this is 0xFE01.
- A requester dropping req_valid without a handshake is legal; no state changes.

Test Plan:
- Reset then idle: rst pulse, all req_valid=0 -> req_ready=0, rsp_valid=0, rsp_data=0, busy=0, mul_a=mul_b=0.
- Single request: req0 a=2, b=3, en=1 -> req_ready=0001 in the same cycle, and rsp_valid=0001 with rsp_data=6 exactly MUL_LAT+1 cycles later for one cycle, then busy=0.
- Full contention: all four valid, req_i a=i+1, b=10 -> grants in order 0,1,2,3,0..., and responses 10,20,30,40 in consecutive cycles tagged 0001, 0010, 0100, 1000.
- Pointer wrap and skip: ptr=3 after granting req2; req3 idle, req0 and req1 valid -> req0 granted, then req1; ptr then 2.
- en gating and drain: issue 2 ops, then en=0 with all valid -> req_ready=0, both responses still arrive, busy falls, ptr unchanged.
- Reset mid-flight plus max operands: issue a=255, b=255, assert rst before the response -> no rsp_valid ever for it. After release, reissue -> rsp_data=0xFE01.
